// File: rtl/mmio_tx_mailbox.sv
// Bus-mapped TX mailbox: CPU pushes words through a DATA register, an external
// device drains them over a valid/ready stream. Status/control and wait states included.
module mmio_tx_mailbox #(
   parameter int DEPTH = 8,
   parameter int WAIT  = 1,
   parameter int CW    = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        ready,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        readyout,
   output logic        dev_valid,
   output logic [31:0] dev_data,
   input  logic        dev_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   localparam logic [3:0]    WAIT_INIT = 4'(WAIT);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

   logic [1:0]    state;
   logic [3:0]    wait_cnt;
   logic [1:0]    off_q;
   logic          write_q;
   logic [31:0]   wdata_q;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   logic          resp;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push_req;
   logic          push_ok;
   logic          ovf_evt;
   logic          udf_evt;
   logic          flush;
   logic          clr;
   logic [31:0]   status;
   logic [31:0]   read_val;

   // Only the word offset inside the window matters; the decoder handles the rest.
   logic          unused_addr;
   assign unused_addr = ^{addr[31:4], addr[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sel && ready) begin
                  state    <= (WAIT == 0) ? ST_RESP : ST_WAIT;
                  wait_cnt <= WAIT_INIT;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) state <= ST_RESP;
            end
            ST_RESP: state <= ST_DONE;
            // Hold here until the initiator drops its strobe so it is not re-accepted.
            ST_DONE: if (!ready || !sel) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_IDLE && sel && ready) begin
         off_q   <= addr[3:2];
         write_q <= write;
         wdata_q <= wdata;
      end
   end

   always_comb begin
      resp     = (state == ST_RESP);
      empty    = (count == '0);
      full     = (count == FULL_CNT);
      pop      = !empty && dev_ready;
      push_req = resp && write_q && (off_q == OFF_DATA);
      // A pop in the same cycle frees the slot the push needs.
      push_ok  = push_req && (!full || pop);
      ovf_evt  = push_req && full && !pop;
      udf_evt  = resp && !write_q && (off_q == OFF_DATA) && empty;
      flush    = resp && write_q && (off_q == OFF_CTRL) && wdata_q[0];
      clr      = resp && write_q && (off_q == OFF_CTRL) && wdata_q[1];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            case ({push_ok, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
         if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (ovf_evt) overflow  <= 1'b1;
            if (udf_evt) underflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata_q;
   end

   always_comb begin
      status         = '0;
      status[CW-1:0] = count;
      status[16]     = empty;
      status[17]     = full;
      status[18]     = overflow;
      status[19]     = underflow;
   end

   always_comb begin
      case (off_q)
         OFF_DATA:   read_val = empty ? 32'd0 : mem[rd_ptr];
         OFF_STATUS: read_val = status;
         default:    read_val = 32'd0;
      endcase
   end

   assign readyout  = resp;
   assign rdata     = (resp && !write_q) ? read_val : 32'd0;
   assign dev_valid = !empty;
   assign dev_data  = empty ? 32'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_mmio_tx_mailbox.sv
// Self-checking bench for mmio_tx_mailbox: directed scenarios then random traffic,
// all compared against a queue-based model of the mailbox.
module tb_mmio_tx_mailbox;

   localparam int DEPTH    = 8;
   localparam int WAIT_CYC = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        ready;
   logic        write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        readyout;
   logic        dev_valid;
   logic [31:0] dev_data;
   logic        dev_ready;

   mmio_tx_mailbox #(.DEPTH(DEPTH), .WAIT(WAIT_CYC), .CW(9)) dut (
      .clk(clk), .rst(rst), .sel(sel), .ready(ready), .write(write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .readyout(readyout),
      .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(dev_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] q[$];
   bit          ov;
   bit          uf;
   bit          rand_dev;
   bit          resp_pending;
   bit          op_write;
   logic [1:0]  op_off;
   logic [31:0] op_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] off);
      logic [31:0] r;
      r = 32'd0;
      if (off == 2'd0) begin
         if (q.size() != 0) r = q[0];
      end else if (off == 2'd1) begin
         r = 32'(q.size());
         r[16] = (q.size() == 0);
         r[17] = (q.size() == DEPTH);
         r[18] = ov;
         r[19] = uf;
      end
      return r;
   endfunction

   // Advance one clock; the model applies the effects the spec defines for that edge.
   task automatic step();
      bit pop;
      bit do_push;
      bit do_flush;
      bit do_clr;
      if (rand_dev) dev_ready = 1'($urandom_range(0, 1));
      if (!rst) begin
         @(posedge clk); #1;
         q.delete();
         ov = 0;
         uf = 0;
         resp_pending = 0;
      end else begin
         pop = dev_ready && (q.size() != 0);
         do_push = 0; do_flush = 0; do_clr = 0;
         if (resp_pending) begin
            if (op_write && op_off == 2'd0) do_push = 1;
            if (op_write && op_off == 2'd2) begin
               do_flush = op_data[0];
               do_clr   = op_data[1];
            end
            if (!op_write && op_off == 2'd0 && q.size() == 0) uf = 1;
         end
         @(posedge clk); #1;
         resp_pending = 0;
         if (do_flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (do_push) begin
               if (q.size() < DEPTH) q.push_back(op_data);
               else ov = 1;
            end
         end
         if (do_clr) begin
            ov = 0;
            uf = 0;
         end
      end
      chk("dev_valid", {31'd0, dev_valid}, {31'd0, (q.size() != 0)});
      chk("dev_data", dev_data, (q.size() != 0) ? q[0] : 32'd0);
   endtask

   task automatic bus(input string tag, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int hold, input bit pop_resp);
      sel = 1; ready = 1; write = wr; addr = a; wdata = d;
      step();
      // Scramble the bus while waiting: the latched request must be used.
      addr  = $urandom;
      wdata = $urandom;
      for (int i = 0; i < WAIT_CYC; i++) begin
         chk({tag, "_wait_readyout"}, {31'd0, readyout}, 32'd0);
         chk({tag, "_wait_rdata"}, rdata, 32'd0);
         step();
      end
      if (pop_resp) dev_ready = 1;
      chk({tag, "_readyout"}, {31'd0, readyout}, 32'd1);
      if (!wr) chk({tag, "_rdata"}, rdata, model_read(a[3:2]));
      resp_pending = 1; op_write = wr; op_off = a[3:2]; op_data = d;
      step();
      if (pop_resp) dev_ready = 0;
      chk({tag, "_done_readyout"}, {31'd0, readyout}, 32'd0);
      chk({tag, "_done_rdata"}, rdata, 32'd0);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_held_readyout"}, {31'd0, readyout}, 32'd0);
      end
      if ($urandom_range(0, 1) == 0) ready = 0; else sel = 0;
      step();
      sel = 0; ready = 0;
   endtask

   task automatic drain();
      dev_ready = 1;
      for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) step();
      dev_ready = 0;
      chk("drain_empty", {31'd0, dev_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      int          r;
      rst = 0; sel = 0; ready = 0; write = 0; addr = 0; wdata = 0;
      dev_ready = 0; rand_dev = 0; resp_pending = 0; ov = 0; uf = 0;

      step(); step();
      rst = 1;
      chk("rst_readyout", {31'd0, readyout}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      bus("rst_status", 0, 32'h0000_0004, 0, 0, 0);

      bus("wr_deadbeef", 1, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 0, 0);
      chk("deadbeef_head", dev_data, 32'hDEAD_BEEF);
      bus("status_one", 0, 32'h1000_0004, 0, 0, 0);
      bus("rd_head", 0, 32'h0000_0000, 0, 0, 0);
      drain();

      for (int i = 0; i < 9; i++) bus("fill", 1, 32'h0, 32'(i), 0, 0);
      bus("status_full_ovf", 0, 32'h4, 0, 0, 0);
      bus("wr_a5_poppush", 1, 32'h0, 32'hA5, 0, 1);
      bus("status_after_a5", 0, 32'h4, 0, 0, 0);
      drain();

      bus("held_strobe", 1, 32'h0, 32'h77, 5, 0);
      bus("status_held", 0, 32'h4, 0, 0, 0);
      drain();

      bus("rd_empty", 0, 32'h0, 0, 0, 0);
      bus("status_udf", 0, 32'h4, 0, 0, 0);
      for (int i = 0; i < 3; i++) bus("queue3", 1, 32'h0, 32'h100 + 32'(i), 0, 0);
      bus("wr_status_ignored", 1, 32'h4, 32'hFFFF_FFFF, 0, 0);
      bus("wr_unmapped", 1, 32'hC, 32'h3, 0, 0);
      bus("rd_ctrl", 0, 32'h8, 0, 0, 0);
      bus("rd_unmapped", 0, 32'hC, 0, 0, 0);
      bus("ctrl_flush_clr", 1, 32'h8, 32'h3, 0, 0);
      bus("status_cleared", 0, 32'h4, 0, 0, 0);

      sel = 1; ready = 1; write = 1; addr = 32'h0; wdata = 32'h5555_AAAA;
      step();
      rst = 0; sel = 0; ready = 0;
      step();
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         chk("midwait_rst_readyout", {31'd0, readyout}, 32'd0);
         step();
      end
      bus("status_after_rst", 0, 32'h4, 0, 0, 0);

      rand_dev = 1;
      for (int n = 0; n < 150; n++) begin
         r  = $urandom_range(0, 9);
         ra = $urandom;
         case (r)
            0, 1, 2, 3, 4: begin ra[3:2] = 2'd0; bus("rnd_push", 1, ra, $urandom, $urandom_range(0, 2), 0); end
            5:       begin ra[3:2] = 2'd0; bus("rnd_rd_data", 0, ra, 0, $urandom_range(0, 2), 0); end
            6:       begin ra[3:2] = 2'd1; bus("rnd_rd_status", 0, ra, 0, $urandom_range(0, 2), 0); end
            7:       begin ra[3:2] = 2'd2; bus("rnd_ctrl", 1, ra, $urandom, 0, 0); end
            8:       bus("rnd_rd_other", 0, ra, 0, 0, 0);
            default: begin ra[3:2] = 2'($urandom_range(1, 3)); if (ra[3:2] == 2'd2) ra[3:2] = 2'd3; bus("rnd_wr_ignored", 1, ra, $urandom, 0, 0); end
         endcase
      end
      rand_dev = 0;
      bus("rnd_final_status", 0, 32'h4, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
